// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the MIPS pipeline stage registers.
//   - default widths used when a stage is instantiated without overrides
//   - packed payload layouts for the ID/EX and EX/MEM boundaries
//   - the all-zero payload that a bubble carries (decodes as NOP)
package pipe_pkg;

    localparam int PIPE_DATA_W   = 128;
    localparam int PIPE_STICKY_W = 1;
    localparam int PIPE_CNT_W    = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [5:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic        is_branch;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    localparam logic [PIPE_DATA_W-1:0] PIPE_ZERO_PAYLOAD = '0;

endpackage

// File: rtl/pipe_stage_reg_pipe_slot.sv
// pipe_slot
// One valid/data/sticky holding register.
//   clk      : rising-edge clock
//   clr      : synchronous clear of valid, data and sticky (highest priority)
//   load     : capture load_d / load_s and set valid
//   drain    : drop to a bubble (valid=0, data=0); sticky is kept
//   load_d   : payload to capture
//   load_s   : sticky field to capture
//   v, d, s  : registered valid, payload, sticky
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W   = PIPE_DATA_W,
    parameter int STICKY_W = PIPE_STICKY_W
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                load,
    input  logic                drain,
    input  logic [DATA_W-1:0]   load_d,
    input  logic [STICKY_W-1:0] load_s,
    output logic                v,
    output logic [DATA_W-1:0]   d,
    output logic [STICKY_W-1:0] s
);

    always_ff @(posedge clk) begin
        if (clr) begin
            v <= 1'b0;
            d <= '0;
            s <= '0;
        end else if (load) begin
            v <= 1'b1;
            d <= load_d;
            s <= load_s;
        end else if (drain) begin
            // Data is zeroed so an empty slot always presents a NOP.
            v <= 1'b0;
            d <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Generic valid/ready pipeline stage with a sticky side field and a
// saturating stall counter.  Build option: PIPE_STAGE_SKID_EN adds a skid
// slot so that up_ready is a register with no path from down_ready.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : clears the datapath (not the stall counter)
//   up_*         : upstream valid/ready/payload/sticky
//   down_*       : downstream valid/ready/payload/sticky
//   occupancy    : entries held (0..1, or 0..2 with skid)
//   stall_cnt    : saturating count of cycles with down_valid & ~down_ready
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = PIPE_DATA_W,
    parameter int STICKY_W = PIPE_STICKY_W,
    parameter int CNT_W    = PIPE_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                up_valid,
    output logic                up_ready,
    input  logic [DATA_W-1:0]   up_data,
    input  logic [STICKY_W-1:0] up_sticky,
    output logic                down_valid,
    input  logic                down_ready,
    output logic [DATA_W-1:0]   down_data,
    output logic [STICKY_W-1:0] down_sticky,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cnt
);

    logic                main_v;
    logic [DATA_W-1:0]   main_d;
    logic [STICKY_W-1:0] main_s;
    logic                main_load;
    logic                main_drain;
    logic [DATA_W-1:0]   main_load_d;
    logic [STICKY_W-1:0] main_load_s;
    logic                up_fire;
    logic                down_fire;
    logic                clr;

    assign clr       = rst | flush;
    assign up_fire   = up_valid & up_ready;
    assign down_fire = main_v & down_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic                skid_v;
    logic [DATA_W-1:0]   skid_d;
    logic [STICKY_W-1:0] skid_s;
    logic                skid_load;
    logic                skid_drain;

    // skid_v is a flop, so up_ready carries no combinational path.
    assign up_ready = ~skid_v;

    // While the skid holds an entry up_ready is low, so up_fire cannot
    // coincide with a skid-to-main transfer.
    assign skid_load   = up_fire & main_v & ~down_ready;
    assign skid_drain  = down_fire & skid_v;
    assign main_load   = skid_drain | (up_fire & (~main_v | down_ready));
    assign main_drain  = down_fire;
    assign main_load_d = skid_v ? skid_d : up_data;
    assign main_load_s = skid_v ? skid_s : up_sticky;

    pipe_slot #(.DATA_W(DATA_W), .STICKY_W(STICKY_W)) u_skid (
        .clk    (clk),
        .clr    (clr),
        .load   (skid_load),
        .drain  (skid_drain),
        .load_d (up_data),
        .load_s (up_sticky),
        .v      (skid_v),
        .d      (skid_d),
        .s      (skid_s)
    );

    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
`else
    assign up_ready    = ~main_v | down_ready;
    assign main_load   = up_fire;
    assign main_drain  = down_fire;
    assign main_load_d = up_data;
    assign main_load_s = up_sticky;
    assign occupancy   = {1'b0, main_v};
`endif

    pipe_slot #(.DATA_W(DATA_W), .STICKY_W(STICKY_W)) u_main (
        .clk    (clk),
        .clr    (clr),
        .load   (main_load),
        .drain  (main_drain),
        .load_d (main_load_d),
        .load_s (main_load_s),
        .v      (main_v),
        .d      (main_d),
        .s      (main_s)
    );

    assign down_valid  = main_v;
    assign down_data   = main_d;
    assign down_sticky = main_s;

    // Flush deliberately leaves the counter alone; it tracks stalls across
    // exceptions for performance monitoring.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_v && !down_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int DW = 16;
    localparam int SW = 1;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          up_valid;
    logic          up_ready;
    logic [DW-1:0] up_data;
    logic [SW-1:0] up_sticky;
    logic          down_valid;
    logic          down_ready;
    logic [DW-1:0] down_data;
    logic [SW-1:0] down_sticky;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(DW), .STICKY_W(SW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_data     (up_data),
        .up_sticky   (up_sticky),
        .down_valid  (down_valid),
        .down_ready  (down_ready),
        .down_data   (down_data),
        .down_sticky (down_sticky),
        .occupancy   (occupancy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0;
        up_sticky = '0; down_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Load something first so reset has state to clear.
        rst = 1'b0; flush = 1'b0; up_valid = 1'b1; up_data = 16'h00F0;
        up_sticky = 1'b1; down_ready = 1'b0;
        step(); step();
        do_reset();
        checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", down_valid); end
        checks++; if (down_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", down_data); end
        checks++; if (down_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %0b want 0", down_sticky); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready got %0b want 1", up_ready); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        up_valid = 1'b1; down_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            up_data = DW'(i);
            step();
            checks++; if (down_valid !== 1'b1 || down_data !== DW'(i)) begin
                errors++; $display("FAIL b2b_data%0d got v=%0b d=%h want v=1 d=%h", i, down_valid, down_data, DW'(i));
            end
            checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %0b want 1", i, up_ready); end
        end
        up_valid = 1'b0;
        step();
        checks++; if (down_valid !== 1'b0 || down_data !== 16'h0) begin
            errors++; $display("FAIL b2b_drain got v=%0b d=%h want v=0 d=0000", down_valid, down_data);
        end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL b2b_stall got %0d want 0", stall_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        up_valid = 1'b1; up_data = 16'h00A5; down_ready = 1'b1;
        step();
        down_ready = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        up_valid = 1'b0;
`else
        // Offered while not ready: must be ignored.
        up_data = 16'h0033;
        #1;
        checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL stall_up_ready got %0b want 0", up_ready); end
`endif
        for (int i = 0; i < 4; i++) step();
        checks++; if (down_valid !== 1'b1 || down_data !== 16'h00A5) begin
            errors++; $display("FAIL stall_hold got v=%0b d=%h want v=1 d=00a5", down_valid, down_data);
        end
        checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL stall_cnt got %0d want 4", stall_cnt); end
        up_valid = 1'b0; down_ready = 1'b1;
        step();
        checks++; if (down_valid !== 1'b0 || stall_cnt !== 4'd4) begin
            errors++; $display("FAIL stall_release got v=%0b cnt=%0d want v=0 cnt=4", down_valid, stall_cnt);
        end
    endtask

    task automatic test_bubble_sticky();
        do_reset();
        up_valid = 1'b1; up_data = 16'h0011; up_sticky = 1'b1; down_ready = 1'b1;
        step();
        checks++; if (down_sticky !== 1'b1 || down_data !== 16'h0011) begin
            errors++; $display("FAIL sticky_load got s=%0b d=%h want s=1 d=0011", down_sticky, down_data);
        end
        up_valid = 1'b0; up_sticky = 1'b0;
        step();
        checks++; if (down_valid !== 1'b0 || down_data !== 16'h0 || down_sticky !== 1'b1) begin
            errors++; $display("FAIL sticky_bubble got v=%0b d=%h s=%0b want v=0 d=0000 s=1", down_valid, down_data, down_sticky);
        end
        step();
        checks++; if (down_sticky !== 1'b1) begin errors++; $display("FAIL sticky_hold got %0b want 1", down_sticky); end
        up_valid = 1'b1; up_data = 16'h0022; up_sticky = 1'b0;
        step();
        checks++; if (down_sticky !== 1'b0 || down_data !== 16'h0022) begin
            errors++; $display("FAIL sticky_replace got s=%0b d=%h want s=0 d=0022", down_sticky, down_data);
        end
        up_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        do_reset();
        up_valid = 1'b1; up_data = 16'h0010; up_sticky = 1'b1; down_ready = 1'b1;
        step();
        up_valid = 1'b0; down_ready = 1'b0;
        step(); step();
        flush = 1'b1; up_valid = 1'b1; up_data = 16'h0055; up_sticky = 1'b1; down_ready = 1'b1;
        step();
        flush = 1'b0; up_valid = 1'b0;
        checks++; if (down_valid !== 1'b0 || down_sticky !== 1'b0 || occupancy !== 2'd0 || down_data !== 16'h0) begin
            errors++; $display("FAIL flush_clear got v=%0b s=%0b occ=%0d d=%h want 0 0 0 0000", down_valid, down_sticky, occupancy, down_data);
        end
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL flush_up_ready got %0b want 1", up_ready); end
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL flush_keeps_cnt got %0d want 2", stall_cnt); end
        step();
        checks++; if (down_valid !== 1'b0 || down_data === 16'h0055) begin
            errors++; $display("FAIL flush_discard got v=%0b d=%h want v=0 d=0000", down_valid, down_data);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        up_valid = 1'b1; up_data = 16'h0077; down_ready = 1'b1;
        step();
        up_valid = 1'b0; down_ready = 1'b0;
        for (int i = 0; i < 14; i++) step();
        checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_mid got %0d want 14", stall_cnt); end
        for (int i = 0; i < 6; i++) step();
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_final got %0d want 15", stall_cnt); end
        down_ready = 1'b1;
        step();
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic test_skid();
        do_reset();
        down_ready = 1'b0; up_valid = 1'b1; up_data = 16'h0007;
        step();
        up_data = 16'h0008;
        step();
        up_valid = 1'b0;
        checks++; if (occupancy !== 2'd2 || up_ready !== 1'b0 || down_data !== 16'h0007) begin
            errors++; $display("FAIL skid_full got occ=%0d rdy=%0b d=%h want 2 0 0007", occupancy, up_ready, down_data);
        end
        down_ready = 1'b1;
        step();
        checks++; if (down_data !== 16'h0008 || up_ready !== 1'b1 || occupancy !== 2'd1) begin
            errors++; $display("FAIL skid_second got d=%h rdy=%0b occ=%0d want 0008 1 1", down_data, up_ready, occupancy);
        end
        step();
        checks++; if (down_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL skid_empty got v=%0b occ=%0d want 0 0", down_valid, occupancy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_bubble_sticky();
        test_flush();
        test_saturation();
`ifdef PIPE_STAGE_SKID_EN
        test_skid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
